// File: rtl/ahb3_pkg.sv
// Shared types and helpers for the AHB3-Lite SRAM slave: transfer encodings,
// response codes, slave FSM states and the byte-lane mask function.
package ahb3_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [1:0] RESP_OKAY  = 2'd0;
  localparam logic [1:0] RESP_ERROR = 2'd1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DONE = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } slave_state_t;

  // Little-endian lane enables for a transfer of 2^hsize bytes at lane offset addr_lsb.
  function automatic logic [7:0] byte_mask(input logic [2:0] addr_lsb, input logic [2:0] hsize);
    logic [15:0] m;
    case (hsize)
      HSIZE_BYTE:  m = 16'h0001;
      HSIZE_HALF:  m = 16'h0003;
      HSIZE_WORD:  m = 16'h000F;
      HSIZE_DWORD: m = 16'h00FF;
      default:     m = 16'h0000;
    endcase
    m = m << addr_lsb;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb3_sram_mem.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
// Contents are deliberately not reset.
module ahb3_sram_mem
  import ahb3_pkg::*;
#(
  parameter  int DATA_width = 32,
  parameter  int MEM_BYTES  = 1024,
  localparam int LANES      = DATA_width / 8,
  localparam int WORDS      = MEM_BYTES / LANES,
  localparam int IDX_W      = $clog2(WORDS)
) (
  input  logic                  clk_i,
  input  logic [LANES-1:0]      we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_width-1:0] wdata_i,
  output logic [DATA_width-1:0] rdata_o
);

  logic [DATA_width-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb3_sram_slave.sv
// AHB3-Lite SRAM slave: registers the address phase, flags illegal or injected-error
// accesses, inserts programmable wait states and drives the two-cycle ERROR response.
module ahb3_sram_slave
  import ahb3_pkg::*;
#(
  parameter int ADD_width   = 32,
  parameter int DATA_width  = 32,
  parameter int RESP_width  = 2,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  hsel,
  input  logic [ADD_width-1:0]  haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_width-1:0] hwdata,
  input  logic                  error,
  output logic [DATA_width-1:0] hrdata,
  output logic                  hready,
  output logic [RESP_width-1:0] hresp,
  output logic [2:0]            dbg_state
);

  localparam int         LANES    = DATA_width / 8;
  localparam int         LSB_W    = $clog2(LANES);
  localparam int         AW       = $clog2(MEM_BYTES);
  localparam int         IDX_W    = AW - LSB_W;
  localparam logic [2:0] MAX_SIZE = 3'(LSB_W);

  // Handshake: an address phase is taken on the rising edge where hsel, an active
  // htrans and hready are all high; its data phase ends on the first later edge
  // with hready high, which is also when write data is sampled.
  slave_state_t          state_q;
  logic                  hready_q;
  logic [RESP_width-1:0] hresp_q;
  logic [3:0]            wait_cnt_q;
  logic                  dphase_q;
  logic                  write_q;
  logic [AW-1:0]         addr_q;
  logic [2:0]            size_q;

  htrans_t               trans;
  logic                  accept;
  logic                  bad;
  logic [ADD_width-1:0]  align_mask;
  logic [7:0]            mask8;
  logic                  commit;
  logic [LANES-1:0]      we;
  logic [DATA_width-1:0] mem_rdata;
  logic                  unused_ok;

  assign trans      = htrans_t'(htrans);
  assign accept     = hsel && hready_q && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);
  assign align_mask = ~({ADD_width{1'b1}} << hsize);
  assign bad        = (haddr >= ADD_width'(MEM_BYTES)) || ((haddr & align_mask) != '0) ||
                      (hsize > MAX_SIZE) || error;

  assign mask8  = byte_mask(3'(addr_q[LSB_W-1:0]), size_q);
  assign commit = dphase_q && write_q && hready_q;
  assign we     = mask8[LANES-1:0] & {LANES{commit}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hready_q   <= 1'b1;
      hresp_q    <= RESP_width'(RESP_OKAY);
      wait_cnt_q <= 4'd0;
      dphase_q   <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= 3'd0;
    end else begin
      if (accept) begin
        addr_q  <= haddr[AW-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
      case (state_q)
        WAIT: begin
          if (wait_cnt_q == 4'd1) begin
            state_q    <= DONE;
            hready_q   <= 1'b1;
            wait_cnt_q <= 4'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all have hready high and take new address phases alike.
          if (accept && bad) begin
            state_q  <= ERR1;
            hready_q <= 1'b0;
            hresp_q  <= RESP_width'(RESP_ERROR);
            dphase_q <= 1'b0;
          end else if (accept && WAIT_STATES > 0) begin
            state_q    <= WAIT;
            hready_q   <= 1'b0;
            hresp_q    <= RESP_width'(RESP_OKAY);
            wait_cnt_q <= 4'(WAIT_STATES);
            dphase_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_width'(RESP_OKAY);
            dphase_q <= accept;
          end
        end
      endcase
    end
  end

  ahb3_sram_mem #(
    .DATA_width (DATA_width),
    .MEM_BYTES  (MEM_BYTES)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we),
    .addr_i  (addr_q[AW-1:LSB_W]),
    .wdata_i (hwdata),
    .rdata_o (mem_rdata)
  );

  assign hrdata    = (dphase_q && !write_q) ? mem_rdata : '0;
  assign hready    = hready_q;
  assign hresp     = hresp_q;
  assign dbg_state = state_q;
  assign unused_ok = ^{hburst, hprot, IDX_W[0]};

endmodule

// File: tb/tb_ahb3_sram_slave.sv
// Bench for ahb3_sram_slave: three instances (0, 3 and 5 wait states) on a shared bus,
// directed pipelined transfers, and a negedge monitor checking against an expected queue.
module tb_ahb3_sram_slave;
  import ahb3_pkg::*;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [2:0]  hsel_v = 3'b000;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'b0011;
  logic [31:0] hwdata = 32'd0;
  logic        error = 1'b0;

  logic [31:0] hrdata_a [NI];
  logic        hready_a [NI];
  logic [1:0]  hresp_a  [NI];
  logic [2:0]  dbg_a    [NI];

  // clock / reset
  always #5 clk = ~clk;

  ahb3_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .error(error), .hrdata(hrdata_a[0]), .hready(hready_a[0]), .hresp(hresp_a[0]),
    .dbg_state(dbg_a[0]));

  ahb3_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .error(error), .hrdata(hrdata_a[1]), .hready(hready_a[1]), .hresp(hresp_a[1]),
    .dbg_state(dbg_a[1]));

  ahb3_sram_slave #(.WAIT_STATES(5)) u_dut2 (
    .clk(clk), .resetn(resetn), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .error(error), .hrdata(hrdata_a[2]), .hready(hready_a[2]), .hresp(hresp_a[2]),
    .dbg_state(dbg_a[2]));

  // scoreboard
  typedef struct {
    int          inst;
    logic [1:0]  resp;
    logic        chk_data;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
  endtask

  task automatic push(input int k, input logic [1:0] resp, input logic chk,
                      input logic [31:0] data, input int waits);
    exp_t e;
    e.inst = k; e.resp = resp; e.chk_data = chk; e.data = data; e.waits = waits;
    exp_q.push_back(e);
  endtask

  // monitor
  logic       pend     [NI] = '{1'b0, 1'b0, 1'b0};
  int         low      [NI] = '{0, 0, 0};
  logic [1:0] low_resp [NI] = '{2'd0, 2'd0, 2'd0};

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!resetn) begin
        pend[k] = 1'b0;
      end else begin
        if (!pend[k]) begin
          check($sformatf("idle_ready_resp[%0d]", k), {29'd0, hready_a[k], hresp_a[k]}, 32'h4);
          check($sformatf("idle_hrdata[%0d]", k), hrdata_a[k], 32'd0);
        end else if (!hready_a[k]) begin
          low[k]++;
          low_resp[k] = hresp_a[k];
        end else begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL orphan_completion[%0d]: got a completion, required none", k);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("inst[%0d]", k), 32'(k), 32'(e.inst));
            check($sformatf("hresp[%0d]", k), 32'(hresp_a[k]), 32'(e.resp));
            check($sformatf("wait_cycles[%0d]", k), 32'(low[k]), 32'(e.waits));
            if (e.waits > 0)
              check($sformatf("wait_hresp[%0d]", k), 32'(low_resp[k]), 32'(e.resp));
            if (e.chk_data)
              check($sformatf("hrdata[%0d]", k), hrdata_a[k], e.data);
          end
          pend[k] = 1'b0;
        end
        if (hsel_v[k] && htrans[1] && hready_a[k]) begin
          pend[k]     = 1'b1;
          low[k]      = 0;
          low_resp[k] = 2'd0;
        end
      end
    end
  end

  // driver: one beat presents an address phase (or IDLE) plus data for the previous
  // transfer, then waits for the edge on which hready is high.
  task automatic beat(input int k, input logic vld, input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic er, input logic [31:0] wd);
    hsel_v = vld ? (3'b001 << k) : 3'b000;
    htrans = vld ? 2'b10 : 2'b00;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    error  = er;
    hwdata = wd;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (hready_a[k]) break;
      if (c >= 50) begin
        n_checks++;
        $display("FAIL beat_timeout[%0d]: hready low for %0d cycles, required completion", k, c);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_beat(input int k, input logic [31:0] wd);
    beat(k, 1'b0, 32'd0, 1'b0, HSIZE_WORD, 1'b0, wd);
  endtask

  initial begin
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_hready[%0d]", k), 32'(hready_a[k]), 32'd1);
      check($sformatf("reset_hresp[%0d]", k), 32'(hresp_a[k]), 32'(RESP_OKAY));
      check($sformatf("reset_hrdata[%0d]", k), hrdata_a[k], 32'd0);
      check($sformatf("reset_state[%0d]", k), 32'(dbg_a[k]), 32'(IDLE));
    end
    @(posedge clk); #1;

    // zero waits: write then pipelined read of the same address
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h10, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    push(0, RESP_OKAY, 1'b1, 32'hDEADBEEF, 0);
    beat(0, 1'b1, 32'h10, 1'b0, HSIZE_WORD, 1'b0, 32'hDEADBEEF);
    idle_beat(0, 32'd0);

    // halfword merge over a word, then misaligned halfword
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h10, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h12, 1'b1, HSIZE_HALF, 1'b0, 32'h11223344);
    push(0, RESP_OKAY, 1'b1, 32'hAAAA3344, 0);
    beat(0, 1'b1, 32'h10, 1'b0, HSIZE_WORD, 1'b0, 32'hAAAA5555);
    push(0, RESP_ERROR, 1'b0, 32'd0, 1);
    beat(0, 1'b1, 32'h11, 1'b1, HSIZE_HALF, 1'b0, 32'd0);
    push(0, RESP_OKAY, 1'b1, 32'hAAAA3344, 0);
    beat(0, 1'b1, 32'h10, 1'b0, HSIZE_WORD, 1'b0, 32'hFFFFFFFF);
    idle_beat(0, 32'd0);

    // out-of-range write leaves the last word untouched
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h3FC, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    push(0, RESP_ERROR, 1'b0, 32'd0, 1);
    beat(0, 1'b1, 32'h400, 1'b1, HSIZE_WORD, 1'b0, 32'hCAFEF00D);
    push(0, RESP_OKAY, 1'b1, 32'hCAFEF00D, 0);
    beat(0, 1'b1, 32'h3FC, 1'b0, HSIZE_WORD, 1'b0, 32'hFFFFFFFF);
    idle_beat(0, 32'd0);

    // injected error, byte lane write, oversize transfer
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h0, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    push(0, RESP_ERROR, 1'b0, 32'd0, 1);
    beat(0, 1'b1, 32'h0, 1'b1, HSIZE_WORD, 1'b1, 32'h01020304);
    push(0, RESP_OKAY, 1'b1, 32'h01020304, 0);
    beat(0, 1'b1, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 32'hFFFFFFFF);
    push(0, RESP_OKAY, 1'b0, 32'd0, 0);
    beat(0, 1'b1, 32'h3, 1'b1, HSIZE_BYTE, 1'b0, 32'd0);
    push(0, RESP_OKAY, 1'b1, 32'hEE020304, 0);
    beat(0, 1'b1, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 32'hEEEEEEEE);
    push(0, RESP_ERROR, 1'b0, 32'd0, 1);
    beat(0, 1'b1, 32'h0, 1'b0, HSIZE_DWORD, 1'b0, 32'd0);
    idle_beat(0, 32'd0);

    // three wait states
    push(1, RESP_OKAY, 1'b0, 32'd0, 3);
    beat(1, 1'b1, 32'h20, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    push(1, RESP_OKAY, 1'b1, 32'h0BADF00D, 3);
    beat(1, 1'b1, 32'h20, 1'b0, HSIZE_WORD, 1'b0, 32'h0BADF00D);
    idle_beat(1, 32'd0);

    // five wait states with a reset pulse mid-wait
    push(2, RESP_OKAY, 1'b0, 32'd0, 5);
    beat(2, 1'b1, 32'h40, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    idle_beat(2, 32'h55555555);
    beat(2, 1'b1, 32'h40, 1'b1, HSIZE_WORD, 1'b0, 32'd0);
    hsel_v = 3'b000;
    htrans = 2'b00;
    hwdata = 32'h12345678;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_hready", 32'(hready_a[2]), 32'd1);
    check("rst_mid_hresp", 32'(hresp_a[2]), 32'(RESP_OKAY));
    check("rst_mid_hrdata", hrdata_a[2], 32'd0);
    check("rst_mid_state", 32'(dbg_a[2]), 32'(IDLE));
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    push(2, RESP_OKAY, 1'b1, 32'h55555555, 5);
    beat(2, 1'b1, 32'h40, 1'b0, HSIZE_WORD, 1'b0, 32'd0);
    idle_beat(2, 32'd0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
